pipe_skid_reg: RTL
==================

Name: pipe_skid_reg

Overview:
- Parametrised pipeline stage register, the successor to the fixed ID/EX-style stall/flush register. It carries an opaque DATA_W-bit payload between CPU pipeline stages.
- Replaces the global stall input with a per-stage valid/ready handshake.
- An optional 2-entry skid buffer gives full throughput with registered back-pressure.
- Flush loads a configurable NOP payload and counts discarded instructions for debug.

Parameters:
- DATA_W, 32, payload width in bits (packed alu_op/operands/mem_op/dst/exp_code etc., packed by the instantiating stage).
- NOP_DATA, {DATA_W{1'b0}}, payload value driven on out_data after reset, flush or when the stage is empty.
- SKID_EN, 1, 1 = two-entry skid buffer (main + skid); 0 = single register.
- CNT_W, 8, width of the flush-drop counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  discard all held entries this cycle (from hazard/exception control).
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept a payload this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  out_data holds a valid payload.
- out_ready  in  1  downstream accepts out_data this cycle.
- out_data  out  DATA_W  payload to downstream; NOP_DATA when out_valid=0.
- occupancy  out  2  number of held entries (0..2; max 1 when SKID_EN=0).
- drop_cnt  out  CNT_W  saturating count of valid entries discarded by flush.

Behaviour:
- Definitions: accept = in_valid & in_ready; emit = out_valid & out_ready.
- States: EMPTY (0 entries), BUSY (main valid), FULL (main + skid valid; SKID_EN=1 only).
- out_valid = (state != EMPTY); out_data = main register; occupancy = 0/1/2 for EMPTY/BUSY/FULL.
- in_ready, SKID_EN=1: (state != FULL) & ~flush. Depends on state and flush only, never on out_ready.
- in_ready, SKID_EN=0: (~out_valid | out_ready) & ~flush. This is a combinational out_ready path by design.
- Reset (reset=0, asynchronous):
  - state EMPTY; main and skid = NOP_DATA; drop_cnt = 0.
  - out_valid = 0; out_data = NOP_DATA; occupancy = 0.
  - in_ready = ~flush.
- Flush (highest priority, overrides all transitions):
  - Next state EMPTY; main and skid <= NOP_DATA.
  - in_data is not accepted that cycle; emit that cycle is still counted as delivered by downstream.
  - drop_cnt += occupancy minus emit, saturating at all-ones.
- EMPTY:
  - accept: main <= in_data, go BUSY.
  - otherwise hold.
- BUSY:
  - accept & emit: main <= in_data, stay BUSY.
  - accept & ~emit: SKID_EN=1 → skid <= in_data, go FULL. Not reachable with SKID_EN=0.
  - ~accept & emit: main <= NOP_DATA, go EMPTY.
  - neither: hold.
- FULL:
  - emit: main <= skid, skid <= NOP_DATA, go BUSY.
  - otherwise hold. No accept is possible in FULL.
- Latency: 1 cycle from accept to out_valid when the stage is empty. Payload order is strictly FIFO.
- Throughput: 1 payload/cycle in steady state for both SKID_EN values.
- Skid register is unused and tied to NOP_DATA when SKID_EN=0.
- drop_cnt never wraps; it clears only on reset.
- Payload never changes while out_valid=1 & out_ready=0 (stable-hold rule, assertion-checked).

Decomposition:
- Shared header pipe.vh:
  - state encodings PIPE_ST_EMPTY=2'd0, PIPE_ST_BUSY=2'd1, PIPE_ST_FULL=2'd2.
  - occupancy width macro.
- Reset polarity/edge macros come from the global config header.
- Stage-specific NOP payloads are built from isa.vh/cpu.vh constants by the instantiating stage.
- One sub-module: sat_counter (CNT_W, increment amount 0..2, saturate) for drop_cnt; reusable for other debug counters.

Test Plan:
- Reset: hold reset=0 for 3 cycles with in_valid=1 → out_valid=0, out_data=NOP_DATA, occupancy=0, drop_cnt=0. After release with flush=0 → in_ready=1.
- Streaming (SKID_EN=1): out_ready=1, push 0x11,0x22,0x33 on consecutive cycles → out_data 0x11,0x22,0x33 on cycles 1,2,3; occupancy stays 1; in_ready never drops.
- Back-pressure: out_ready=0, push 0xA1,0xA2,0xA3.
  - Expected after 2 cycles: occupancy=2, in_ready=0, 0xA3 held upstream.
  - Then out_ready=1 → outputs 0xA1,0xA2,0xA3 in order, no loss or duplicate.
- Flush while FULL: occupancy=2, flush=1 with in_valid=1, out_ready=0 → next cycle occupancy=0, out_data=NOP_DATA, drop_cnt=2, new payload not accepted.
- Saturation: CNT_W=2, repeat full-stage flushes → drop_cnt goes 2, 3, 3.
- SKID_EN=0: out_ready=0 with BUSY → in_ready=0 combinationally. Raise out_ready → in_ready=1 the same cycle; accept and emit together keep occupancy=1.

Source files
------------

// File: rtl/pipe_skid_reg_pkg.sv
// Shared types for the pipeline stage register: state encoding and occupancy helpers.
package pipe_skid_reg_pkg;

  localparam int unsigned OCC_W = 2;

  typedef enum logic [OCC_W-1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // Number of held entries for a given stage state.
  function automatic logic [OCC_W-1:0] occ_of(input state_t st);
    case (st)
      ST_BUSY: return OCC_W'(1);
      ST_FULL: return OCC_W'(2);
      default: return OCC_W'(0);
    endcase
  endfunction

endpackage

// File: rtl/pipe_skid_reg_sat_counter.sv
// Saturating up-counter with a small per-cycle increment; reusable for debug counters.
module pipe_skid_reg_sat_counter
  import pipe_skid_reg_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OCC_W-1:0] inc,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned SUM_W = CNT_W + OCC_W;

  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] max_val;
  logic [CNT_W-1:0] count_d;

  // Extra headroom bits let the overflow be detected before clamping.
  assign sum     = SUM_W'(count) + SUM_W'(inc);
  assign max_val = SUM_W'({CNT_W{1'b1}});

  always_comb begin
    count_d = sum[CNT_W-1:0];
    if (sum > max_val) count_d = {CNT_W{1'b1}};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count <= '0;
    else        count <= count_d;
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake, optional 2-entry skid buffer,
// flush-to-NOP and a saturating count of payloads discarded by flush.
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int unsigned        DATA_W   = 32,
  parameter logic [DATA_W-1:0]  NOP_DATA = '0,
  parameter bit                 SKID_EN  = 1'b1,
  parameter int unsigned        CNT_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [OCC_W-1:0]  occupancy,
  output logic [CNT_W-1:0]  drop_cnt
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              accept;
  logic              emit;
  logic [OCC_W-1:0]  drop_inc;

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign occupancy = occ_of(state_q);

  // Skid mode decouples in_ready from out_ready; single-register mode trades that for area.
  assign in_ready = SKID_EN ? ((state_q != ST_FULL) & ~flush)
                            : ((~out_valid | out_ready) & ~flush);

  assign accept = in_valid & in_ready;
  assign emit   = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
      main_q  <= NOP_DATA;
      skid_q  <= NOP_DATA;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = NOP_DATA;
      skid_d  = NOP_DATA;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_d  = in_data;
            state_d = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (accept && emit) begin
            main_d = in_data;
          end else if (accept && SKID_EN) begin
            skid_d  = in_data;
            state_d = ST_FULL;
          end else if (emit) begin
            main_d  = NOP_DATA;
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (emit) begin
            main_d  = skid_q;
            skid_d  = NOP_DATA;
            state_d = ST_BUSY;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = NOP_DATA;
          skid_d  = NOP_DATA;
        end
      endcase
    end
  end

  // An entry emitted in the flush cycle was delivered downstream, so it is not a drop.
  assign drop_inc = flush ? (occupancy - OCC_W'(emit)) : '0;

  pipe_skid_reg_sat_counter #(
    .CNT_W (CNT_W)
  ) u_drop_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (drop_inc),
    .count (drop_cnt)
  );

  // Held payload must stay stable while downstream stalls.
  assert property (@(posedge clk) disable iff (!reset)
    (out_valid && !out_ready && !flush) |=> $stable(out_data));

endmodule
